// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Accepts symbolic MIPS instruction descriptors over a valid/ready stream,
// encodes each one into a 32-bit instruction word, and writes the words to
// instruction memory at consecutive addresses starting from word 0.
//
// Build option:
//   INSTR_ENC_ILLEGAL_CHECK_EN - when defined, op indices 22..31 are accepted
//   but not written; err_illegal sets and the load ends. When undefined, those
//   indices encode as NOP and are written normally; err_illegal stays 0.
module instr_encoder_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_overflow,
    output logic              err_illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Operation indices as presented on in_op.
    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_ADDU  = 5'd1,
        OP_SUB   = 5'd2,
        OP_SUBU  = 5'd3,
        OP_AND   = 5'd4,
        OP_OR    = 5'd5,
        OP_XOR   = 5'd6,
        OP_NOR   = 5'd7,
        OP_SLT   = 5'd8,
        OP_SLTU  = 5'd9,
        OP_LW    = 5'd10,
        OP_SW    = 5'd11,
        OP_BEQ   = 5'd12,
        OP_BNE   = 5'd13,
        OP_ANDI  = 5'd14,
        OP_ORI   = 5'd15,
        OP_XORI  = 5'd16,
        OP_ADDI  = 5'd17,
        OP_ADDIU = 5'd18,
        OP_SLTI  = 5'd19,
        OP_SLTIU = 5'd20,
        OP_NOP   = 5'd21
    } op_e;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_ovf_q, err_ovf_d;
    logic                err_ill_q, err_ill_d;

    logic                is_rtype;
    logic                is_itype;
    logic [5:0]          funct;
    logic [5:0]          opcode;
    logic                drop_word;
    logic [31:0]         enc_word;
    logic                handshake;

    // Decode the op index into an instruction class plus its funct/opcode field.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave a value held and infer a latch.
        is_rtype  = 1'b0;
        is_itype  = 1'b0;
        funct     = 6'h00;
        opcode    = 6'h00;
        drop_word = 1'b0;
        case (in_op)
            OP_ADD:   begin is_rtype = 1'b1; funct  = 6'h20; end
            OP_ADDU:  begin is_rtype = 1'b1; funct  = 6'h21; end
            OP_SUB:   begin is_rtype = 1'b1; funct  = 6'h22; end
            OP_SUBU:  begin is_rtype = 1'b1; funct  = 6'h23; end
            OP_AND:   begin is_rtype = 1'b1; funct  = 6'h24; end
            OP_OR:    begin is_rtype = 1'b1; funct  = 6'h25; end
            OP_XOR:   begin is_rtype = 1'b1; funct  = 6'h26; end
            OP_NOR:   begin is_rtype = 1'b1; funct  = 6'h27; end
            OP_SLT:   begin is_rtype = 1'b1; funct  = 6'h2A; end
            OP_SLTU:  begin is_rtype = 1'b1; funct  = 6'h2B; end
            OP_LW:    begin is_itype = 1'b1; opcode = 6'h23; end
            OP_SW:    begin is_itype = 1'b1; opcode = 6'h2B; end
            OP_BEQ:   begin is_itype = 1'b1; opcode = 6'h04; end
            OP_BNE:   begin is_itype = 1'b1; opcode = 6'h05; end
            OP_ANDI:  begin is_itype = 1'b1; opcode = 6'h0C; end
            OP_ORI:   begin is_itype = 1'b1; opcode = 6'h0D; end
            OP_XORI:  begin is_itype = 1'b1; opcode = 6'h0E; end
            OP_ADDI:  begin is_itype = 1'b1; opcode = 6'h08; end
            OP_ADDIU: begin is_itype = 1'b1; opcode = 6'h09; end
            OP_SLTI:  begin is_itype = 1'b1; opcode = 6'h0A; end
            OP_SLTIU: begin is_itype = 1'b1; opcode = 6'h0B; end
            OP_NOP:   begin end
            default: begin
`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
                // Unknown op: consume it but never write it.
                drop_word = 1'b1;
`endif
            end
        endcase
    end

    // Assemble the 32-bit word; anything that is neither R nor I is all-zero (NOP).
    always_comb begin
        enc_word = 32'h0000_0000;
        if (is_rtype) begin
            enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b00000, funct};
        end else if (is_itype) begin
            enc_word = {opcode, in_rs, in_rt, in_imm};
        end
    end

    assign handshake = in_valid && (state_q == S_LOAD);

    // Load sequencing: start handling, per-word write, last/overflow/illegal exits.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        err_ovf_d = err_ovf_q;
        err_ill_d = err_ill_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    addr_d    = '0;
                    count_d   = '0;
                    err_ovf_d = 1'b0;
                    err_ill_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (handshake) begin
                    if (drop_word) begin
                        err_ill_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = enc_word;
                        count_d = count_q + COUNT_ONE;
                        if (in_last) begin
                            state_d = S_DONE;
                        end else if (addr_q == ADDR_MAX) begin
                            // Memory is full and the program is not finished:
                            // stop rather than wrap onto word 0.
                            err_ovf_d = 1'b1;
                            state_d   = S_DONE;
                        end else begin
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops any pending write immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_ovf_q <= 1'b0;
            err_ill_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the pre-edge values, independent of statement order.
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_ovf_q <= err_ovf_d;
            err_ill_q <= err_ill_d;
        end
    end

    assign in_ready     = (state_q == S_LOAD);
    assign busy         = (state_q == S_LOAD);
    assign done         = (state_q == S_DONE);
    assign imem_we      = we_q;
    assign imem_addr    = waddr_q;
    assign imem_wdata   = wdata_q;
    assign count        = count_q;
    assign err_overflow = err_ovf_q;
`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
    assign err_illegal  = err_ill_q;
`else
    assign err_illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed descriptors with hand-encoded
// expected words pushed to a scoreboard; a negedge monitor pops and compares
// every memory write. Status outputs are checked just after clock edges.
module tb_instr_encoder_loader;

    localparam int AW = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_op;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [15:0]   in_imm;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          err_overflow;
    logic          err_illegal;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t           exp_q[$];
    logic [AW-1:0] exp_addr;
    int            vectors;
    int            miscompares;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_imm       (in_imm),
        .in_last      (in_last),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .busy         (busy),
        .done         (done),
        .count        (count),
        .err_overflow (err_overflow),
        .err_illegal  (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write (t=%0t)",
                         imem_addr, imem_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_addr = '0;
    endtask

    // Present one descriptor; optionally record the word it should produce.
    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last,
                        input logic push, input logic [31:0] data);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        in_last  = last;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
        end else if (push) begin
            exp_q.push_back('{addr: exp_addr, data: data});
            exp_addr = exp_addr + 1'b1;
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_addr    = '0;
        rst_n       = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_op       = '0;
        in_rs       = '0;
        in_rt       = '0;
        in_rd       = '0;
        in_imm      = '0;
        in_last     = 1'b0;

        // Reset values.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we",       32'(imem_we), 32'd0);
        check("rst_addr",     32'(imem_addr), 32'd0);
        check("rst_wdata",    imem_wdata, 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_count",    32'(count), 32'd0);
        check("rst_ovf",      32'(err_overflow), 32'd0);
        check("rst_ill",      32'(err_illegal), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Single ADD with in_last.
        do_start();
        check("t1_busy",  32'(busy), 32'd1);
        check("t1_ready", 32'(in_ready), 32'd1);
        check("t1_count0", 32'(count), 32'd0);
        send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b1, 1'b1, 32'h0022_1820);
        check("t1_we",    32'(imem_we), 32'd1);
        check("t1_done",  32'(done), 32'd1);
        check("t1_busyl", 32'(busy), 32'd0);
        check("t1_readyl", 32'(in_ready), 32'd0);
        check("t1_count", 32'(count), 32'd1);
        step();
        check("t1_we_off", 32'(imem_we), 32'd0);
        check("t1_done_hold", 32'(done), 32'd1);

        // Overflow: four ADDU words fill memory, the fifth is never accepted.
        do_start();
        send(5'd1, 5'd0, 5'd0, 5'd1, 16'h0000, 1'b0, 1'b1, 32'h0000_0821);
        send(5'd1, 5'd0, 5'd0, 5'd2, 16'h0000, 1'b0, 1'b1, 32'h0000_1021);
        send(5'd1, 5'd0, 5'd0, 5'd3, 16'h0000, 1'b0, 1'b1, 32'h0000_1821);
        send(5'd1, 5'd0, 5'd0, 5'd4, 16'h0000, 1'b0, 1'b1, 32'h0000_2021);
        check("ovf_flag",  32'(err_overflow), 32'd1);
        check("ovf_done",  32'(done), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        in_valid = 1'b1;
        in_op    = 5'd1;
        in_rd    = 5'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ovf_no_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        // Restart after DONE clears flags; LW/SW/BEQ back to back.
        do_start();
        check("t3_ovf_clr", 32'(err_overflow), 32'd0);
        check("t3_count0",  32'(count), 32'd0);
        check("t3_done0",   32'(done), 32'd0);
        send(5'd10, 5'd0, 5'd8, 5'd0, 16'h0004, 1'b0, 1'b1, 32'h8C08_0004);
        send(5'd11, 5'd0, 5'd8, 5'd0, 16'h0008, 1'b0, 1'b1, 32'hAC08_0008);
        send(5'd12, 5'd8, 5'd9, 5'd0, 16'hFFFE, 1'b1, 1'b1, 32'h1109_FFFE);
        check("t3_count", 32'(count), 32'd3);
        check("t3_done",  32'(done), 32'd1);

        // Exact fill with in_last on the final address: no overflow.
        do_start();
        send(5'd2,  5'd4,  5'd5,  5'd6,  16'h0000, 1'b0, 1'b1, 32'h0085_3022);
        send(5'd15, 5'd1,  5'd2,  5'd0,  16'h1234, 1'b0, 1'b1, 32'h3422_1234);
        send(5'd21, 5'd7,  5'd7,  5'd7,  16'h5555, 1'b0, 1'b1, 32'h0000_0000);
        send(5'd9,  5'd31, 5'd31, 5'd31, 16'hFFFF, 1'b1, 1'b1, 32'h03FF_F82B);
        check("t4_ovf",   32'(err_overflow), 32'd0);
        check("t4_done",  32'(done), 32'd1);
        check("t4_count", 32'(count), 32'd4);

        // Reset on the cycle after a handshake drops the pending write.
        do_start();
        send(5'd0, 5'd1, 5'd1, 5'd1, 16'h0000, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",    32'(imem_we), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_addr",  32'(imem_addr), 32'd0);
        check("mid_rst_wdata", imem_wdata, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        do_start();
        check("t5_count0", 32'(count), 32'd0);
        check("t5_busy",   32'(busy), 32'd1);

        // ADDIU then an out-of-range op index.
        send(5'd18, 5'd3, 5'd4, 5'd0, 16'hFFFF, 1'b0, 1'b1, 32'h2464_FFFF);
`ifdef INSTR_ENC_ILLEGAL_CHECK_EN
        send(5'd25, 5'd1, 5'd2, 5'd3, 16'h1111, 1'b1, 1'b0, 32'h0);
        check("ill_flag",  32'(err_illegal), 32'd1);
        check("ill_done",  32'(done), 32'd1);
        check("ill_count", 32'(count), 32'd1);
        check("ill_no_we", 32'(imem_we), 32'd0);
`else
        send(5'd25, 5'd1, 5'd2, 5'd3, 16'h1111, 1'b1, 1'b1, 32'h0000_0000);
        check("ill_flag",  32'(err_illegal), 32'd0);
        check("ill_done",  32'(done), 32'd1);
        check("ill_count", 32'(count), 32'd2);
        check("ill_we",    32'(imem_we), 32'd1);
`endif

        step();
        step();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and instruction-memory loader for the pipelined MIPS core. It accepts symbolic instruction descriptors (operation index, rs, rt, rd, imm16) over a valid/ready stream. It encodes each descriptor into the 32-bit MIPS word that the core's decode stage maps back to the same control vector. It writes the encoded words sequentially into instruction memory, so test programs can be loaded from a bench or a host bridge without precompiled hex files.

## Interface
- ADDR_W, default 10: instruction-memory word-address width; depth = 2^ADDR_W words.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a load at word address 0.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  descriptor accepted when in_valid && in_ready.
- in_op  input  5  operation index (see Operation).
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  immediate / branch offset, inserted verbatim.
- in_last  input  1  marks the final descriptor of a program.
- imem_we  output  1  write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded instruction.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.
- count  output  ADDR_W+1  words written in the current load.
- err_overflow  output  1  sticky: memory full before in_last.
- err_illegal  output  1  sticky: illegal in_op (only with the macro).

## Operation
- FSM states: IDLE, LOAD, DONE. Reset state is IDLE.
  - IDLE → LOAD on start.
  - DONE → LOAD on start.
  - start in LOAD is ignored.
- Entering LOAD clears the address counter, count, err_overflow and err_illegal.
- in_ready = (state == LOAD). There is no backpressure from memory; throughput is 1 word/cycle.
- R-type encoding = {6'h00, rs, rt, rd, 5'b0, funct}. in_imm is ignored.
  - Op indices and funct: 0 ADD 0x20, 1 ADDU 0x21, 2 SUB 0x22, 3 SUBU 0x23, 4 AND 0x24, 5 OR 0x25, 6 XOR 0x26, 7 NOR 0x27, 8 SLT 0x2A, 9 SLTU 0x2B.
- I-type encoding = {opcode, rs, rt, imm}. in_rd is ignored.
  - Op indices and opcode: 10 LW 0x23, 11 SW 0x2B, 12 BEQ 0x04, 13 BNE 0x05, 14 ANDI 0x0C, 15 ORI 0x0D, 16 XORI 0x0E, 17 ADDI 0x08, 18 ADDIU 0x09, 19 SLTI 0x0A, 20 SLTIU 0x0B.
- Index 21 is NOP, encoded as 32'h00000000. Indices 22–31 are illegal (see Configuration).
- Each accepted descriptor produces exactly one write at the current address. The address then increments by 1 and count increments by 1.
- Accepted with in_last: the word is written, then the FSM goes to DONE.
- Word written at address 2^ADDR_W−1 without in_last: the word is written, err_overflow sets, and the FSM goes to DONE. The address never wraps.
- in_last on the last address: the program completes normally and err_overflow stays 0.

## Timing
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, count 0, both error flags 0.
- start at cycle N: busy=1 and in_ready=1 from N+1.
- Handshake at cycle N: imem_we=1 with imem_addr/imem_wdata valid in cycle N+1 (registered output, 1-cycle latency). count reflects the write in N+1.
- Back-to-back handshakes produce back-to-back writes.
- Final handshake at N: in_ready=0 from N+1; done=1 and busy=0 from N+1. The last write still occurs in N+1.
- done holds until the next start; count holds its final value.
- rst_n asserted mid-load: all outputs return to reset values immediately. A pending write is dropped (imem_we forced 0).
- start coincident with a handshake while in DONE/IDLE: the handshake is not possible (in_ready=0); start takes effect.

## Configuration
- INSTR_ENC_ILLEGAL_CHECK_EN defined: in_op 22–31 is accepted but not written. err_illegal sets and the FSM goes to DONE next cycle; count is unchanged.
- Macro undefined: in_op 22–31 encodes as NOP (32'h00000000) and is written normally. err_illegal is tied 0.

## Test plan
- Reset → all outputs 0; start, then ADD rs=1 rt=2 rd=3 with in_last → one write at addr 0, wdata 32'h00221820, done next cycle, count=1.
- Stream LW rs=0 rt=8 imm=0x0004, SW rs=0 rt=8 imm=0x0008, BEQ rs=8 rt=9 imm=0xFFFE (last) → writes 0x8C080004, 0xAC080008, 0x1109FFFE at addrs 0,1,2 on consecutive cycles; count=3.
- ADDR_W=2, five descriptors none last → four writes at addrs 0–3, err_overflow=1, done=1, fifth never accepted.
- rst_n low on the cycle after a handshake → no write issued, outputs 0; new start restarts at addr 0 with count 0.
- in_op=25 with the macro defined → no write, err_illegal=1, done=1. Without the macro → write 32'h00000000, err_illegal=0.
- Second start after DONE → flags cleared, addresses restart at 0.
